// File: rtl/sonar_scan_pkg.sv
// Shared types for the sonar scan control unit: state codes and
// the index-width helper used for the channel and character ports.
package sonar_scan_pkg;

    localparam logic [3:0] C_INICIAL    = 4'd0;
    localparam logic [3:0] C_PREPARA    = 4'd1;
    localparam logic [3:0] C_DISPARA    = 4'd2;
    localparam logic [3:0] C_AGUARDA    = 4'd3;
    localparam logic [3:0] C_TRANSMITE  = 4'd4;
    localparam logic [3:0] C_ESPERA     = 4'd5;
    localparam logic [3:0] C_PROX_CHAR  = 4'd6;
    localparam logic [3:0] C_PROX_CANAL = 4'd7;
    localparam logic [3:0] C_INTERVALO  = 4'd8;
    localparam logic [3:0] C_FINAL      = 4'd9;

    typedef enum logic [3:0] {
        ST_INICIAL    = C_INICIAL,
        ST_PREPARA    = C_PREPARA,
        ST_DISPARA    = C_DISPARA,
        ST_AGUARDA    = C_AGUARDA,
        ST_TRANSMITE  = C_TRANSMITE,
        ST_ESPERA     = C_ESPERA,
        ST_PROX_CHAR  = C_PROX_CHAR,
        ST_PROX_CANAL = C_PROX_CANAL,
        ST_INTERVALO  = C_INTERVALO,
        ST_FINAL      = C_FINAL
    } state_t;

    // Index width for a count of n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sonar_scan_cnt.sv
// Modulo-M counter with synchronous clear, count enable and a
// terminal-count flag raised while the count sits at M-1.
module sonar_scan_cnt #(
    parameter int M = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] value;

    assign tc = (value == W'(M - 1));

    // Count register: clear dominates enable, wraps after M-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (enable) begin
            value <= tc ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/sonar_scan_uc.sv
// Sonar sweep control unit: round-robin trigger, echo wait and per-channel
// character transmission. Optional macro RETRY_EN retries a timed-out channel once.
module sonar_scan_uc
    import sonar_scan_pkg::*;
#(
    parameter int N_CANAIS    = 2,
    parameter int N_CHARS     = 4,
    parameter int TIMEOUT_MED = 1500000,
    parameter int INTERVALO   = 50000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              mensurar,
    input  logic                              continuo,
    input  logic                              parar,
    input  logic                              fim_medida,
    input  logic                              fim_digito,
    output logic                              zera,
    output logic                              comeca_medida,
    output logic                              partida,
    output logic [idx_width(N_CANAIS)-1:0]    canal,
    output logic [idx_width(N_CHARS)-1:0]     indice_char,
    output logic [N_CANAIS-1:0]               erro_canal,
    output logic                              fim_varredura,
    output logic                              pronto,
    output logic                              ocupado,
    output logic [3:0]                        db_estado
);

    localparam int CW = idx_width(N_CANAIS);
    localparam int IW = idx_width(N_CHARS);
    localparam logic [CW-1:0] CANAL_ULT = CW'(N_CANAIS - 1);
    localparam logic [IW-1:0] CHAR_ULT  = IW'(N_CHARS - 1);

    state_t state;
    state_t next;

    logic stop_q;
    logic stop_req;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_tc;
    logic int_clr;
    logic int_en;
    logic int_tc;
    logic canal_clr;
    logic canal_inc;
    logic idx_clr;
    logic idx_inc;
    logic erro_set;
    logic erro_clr;
    logic stop_clr;
    logic last_canal;
    logic last_char;

`ifdef RETRY_EN
    logic retry_q;
    logic retry_set;
    logic retry_clr;
`endif

    // A stop pending in the latch or arriving this cycle both count.
    assign stop_req   = stop_q | parar;
    assign last_canal = (canal == CANAL_ULT);
    assign last_char  = (indice_char == CHAR_ULT);
    assign int_clr    = (state != ST_INTERVALO);
    assign ocupado    = (state != ST_INICIAL);
    assign db_estado  = state;

    sonar_scan_cnt #(.M(TIMEOUT_MED)) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clr),
        .enable (tmo_en),
        .tc     (tmo_tc)
    );

    sonar_scan_cnt #(.M(INTERVALO)) u_int (
        .clock  (clock),
        .reset  (reset),
        .clear  (int_clr),
        .enable (int_en),
        .tc     (int_tc)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INICIAL;
        end else begin
            state <= next;
        end
    end

    // Channel, character, error and stop-latch registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            canal       <= '0;
            indice_char <= '0;
            erro_canal  <= '0;
            stop_q      <= 1'b0;
        end else begin
            if (canal_clr) begin
                canal <= '0;
            end else if (canal_inc) begin
                canal <= canal + CW'(1);
            end
            if (idx_clr) begin
                indice_char <= '0;
            end else if (idx_inc) begin
                indice_char <= indice_char + IW'(1);
            end
            if (erro_clr) begin
                erro_canal <= '0;
            end else if (erro_set) begin
                erro_canal[canal] <= 1'b1;
            end
            if (stop_clr) begin
                stop_q <= 1'b0;
            end else if (parar) begin
                stop_q <= 1'b1;
            end
        end
    end

`ifdef RETRY_EN
    // Marks that the current channel has already used its one retry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_q <= 1'b0;
        end else if (retry_clr) begin
            retry_q <= 1'b0;
        end else if (retry_set) begin
            retry_q <= 1'b1;
        end
    end
`endif

    // Next-state and output decode.
    always_comb begin
        next          = state;
        zera          = 1'b0;
        comeca_medida = 1'b0;
        partida       = 1'b0;
        fim_varredura = 1'b0;
        pronto        = 1'b0;
        tmo_clr       = 1'b0;
        tmo_en        = 1'b0;
        int_en        = 1'b0;
        canal_clr     = 1'b0;
        canal_inc     = 1'b0;
        idx_clr       = 1'b0;
        idx_inc       = 1'b0;
        erro_set      = 1'b0;
        erro_clr      = 1'b0;
        stop_clr      = 1'b0;
`ifdef RETRY_EN
        retry_set     = 1'b0;
        retry_clr     = 1'b0;
`endif
        case (state)
            ST_INICIAL: begin
                zera      = 1'b1;
                canal_clr = 1'b1;
                idx_clr   = 1'b1;
                stop_clr  = 1'b1;
`ifdef RETRY_EN
                retry_clr = 1'b1;
`endif
                if (mensurar) begin
                    erro_clr = 1'b1;
                    next     = ST_PREPARA;
                end
            end
            ST_PREPARA: begin
                zera    = 1'b1;
                idx_clr = 1'b1;
                tmo_clr = 1'b1;
                next    = ST_DISPARA;
            end
            ST_DISPARA: begin
                comeca_medida = 1'b1;
                next          = ST_AGUARDA;
            end
            ST_AGUARDA: begin
                tmo_en = 1'b1;
                if (fim_medida) begin
                    next = ST_TRANSMITE;
                end else if (tmo_tc) begin
`ifdef RETRY_EN
                    if (!retry_q) begin
                        retry_set = 1'b1;
                        next      = ST_PREPARA;
                    end else begin
                        erro_set = 1'b1;
                        next     = ST_PROX_CANAL;
                    end
`else
                    erro_set = 1'b1;
                    next     = ST_PROX_CANAL;
`endif
                end
            end
            ST_TRANSMITE: begin
                partida = 1'b1;
                next    = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (fim_digito) begin
                    next = ST_PROX_CHAR;
                end
            end
            ST_PROX_CHAR: begin
                if (last_char) begin
                    next = ST_PROX_CANAL;
                end else begin
                    idx_inc = 1'b1;
                    next    = ST_TRANSMITE;
                end
            end
            ST_PROX_CANAL: begin
`ifdef RETRY_EN
                retry_clr = 1'b1;
`endif
                if (last_canal) begin
                    fim_varredura = 1'b1;
                    canal_clr     = 1'b1;
                    if (stop_req || !continuo) begin
                        next = ST_FINAL;
                    end else begin
                        next = ST_INTERVALO;
                    end
                end else begin
                    canal_inc = 1'b1;
                    if (stop_req) begin
                        next = ST_FINAL;
                    end else begin
                        next = ST_PREPARA;
                    end
                end
            end
            ST_INTERVALO: begin
                int_en = 1'b1;
                if (stop_req) begin
                    next = ST_FINAL;
                end else if (int_tc) begin
                    erro_clr = 1'b1;
                    next     = ST_PREPARA;
                end
            end
            ST_FINAL: begin
                pronto = 1'b1;
                next   = ST_INICIAL;
            end
            default: begin
                next = ST_INICIAL;
            end
        endcase
    end

endmodule

// File: tb/tb_sonar_scan_uc.sv
// Directed bench for sonar_scan_uc with a small echo/tx responder.
// Runs the default build; RETRY_EN switches the expected retry values.
module tb_sonar_scan_uc;

    localparam int NC   = 2;
    localparam int NCH  = 4;
    localparam int TMO  = 30;
    localparam int INTV = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mensurar = 1'b0;
    logic       continuo = 1'b0;
    logic       parar = 1'b0;
    logic       fim_medida = 1'b0;
    logic       fim_digito = 1'b0;
    logic       zera;
    logic       comeca_medida;
    logic       partida;
    logic [0:0] canal;
    logic [1:0] indice_char;
    logic [1:0] erro_canal;
    logic       fim_varredura;
    logic       pronto;
    logic       ocupado;
    logic [3:0] db_estado;

    int n_assert = 0;
    int n_fail   = 0;

    int         meas_delay = 10;
    int         dig_delay  = 5;
    logic [1:0] dead = 2'b00;
    int         mcnt = 0;
    int         dcnt = 0;
    int         cyc = 0;
    int         fd_cyc = -100;
    int         n_comeca = 0;
    int         n_partida = 0;
    int         n_fv = 0;
    int         n_pronto = 0;
    int         fast_gap = 0;
    int         part_ch [2];
    int         log_canal [8];

`ifdef RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    sonar_scan_uc #(
        .N_CANAIS    (NC),
        .N_CHARS     (NCH),
        .TIMEOUT_MED (TMO),
        .INTERVALO   (INTV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mensurar      (mensurar),
        .continuo      (continuo),
        .parar         (parar),
        .fim_medida    (fim_medida),
        .fim_digito    (fim_digito),
        .zera          (zera),
        .comeca_medida (comeca_medida),
        .partida       (partida),
        .canal         (canal),
        .indice_char   (indice_char),
        .erro_canal    (erro_canal),
        .fim_varredura (fim_varredura),
        .pronto        (pronto),
        .ocupado       (ocupado),
        .db_estado     (db_estado)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Echo and tx responder plus event monitor, on the falling edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        fim_medida = 1'b0;
        fim_digito = 1'b0;
        if (reset) begin
            mcnt = 0;
            dcnt = 0;
        end else begin
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) fim_medida = 1'b1;
            end
            if (dcnt > 0) begin
                dcnt = dcnt - 1;
                if (dcnt == 0) begin
                    fim_digito = 1'b1;
                    fd_cyc = cyc;
                end
            end
            if (comeca_medida) begin
                if (n_comeca < 8) log_canal[n_comeca] = int'(canal);
                n_comeca = n_comeca + 1;
                if (!dead[canal]) mcnt = meas_delay;
            end
            if (partida) begin
                n_partida = n_partida + 1;
                part_ch[canal] = part_ch[canal] + 1;
                if (cyc - fd_cyc == 2) fast_gap = fast_gap + 1;
                dcnt = dig_delay;
            end
            if (fim_varredura) n_fv = n_fv + 1;
            if (pronto) n_pronto = n_pronto + 1;
        end
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic clear_stats();
        n_comeca = 0;
        n_partida = 0;
        n_fv = 0;
        n_pronto = 0;
        fast_gap = 0;
        fd_cyc = -100;
        part_ch[0] = 0;
        part_ch[1] = 0;
        for (int i = 0; i < 8; i++) log_canal[i] = -1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (db_estado == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start();
        mensurar = 1'b1;
        step();
        mensurar = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1;
        repeat (3) step();
        n_assert++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0 || zera !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: estado=%0d ocupado=%b zera=%b want 0/0/1",
                     db_estado, ocupado, zera);
        end
        n_assert++;
        if (canal !== 1'b0 || indice_char !== 2'd0 || erro_canal !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idx: canal=%0d idx=%0d erro=%b want 0/0/00",
                     canal, indice_char, erro_canal);
        end
        n_assert++;
        if ({comeca_medida, partida, fim_varredura, pronto} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {comeca_medida, partida, fim_varredura, pronto});
        end
        reset = 1'b0;
        step();
        n_assert++;
        if (db_estado !== 4'd0 || zera !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold: estado=%0d zera=%b want 0/1", db_estado, zera);
        end
        ok = 1'b1;
    endtask

    task automatic test_single_sweep();
        bit ok;
        clear_stats();
        continuo = 1'b0;
        start();
        n_assert++;
        if (db_estado !== 4'd1 || zera !== 1'b1) begin
            n_fail++;
            $display("FAIL prepara: estado=%0d zera=%b want 1/1", db_estado, zera);
        end
        step();
        n_assert++;
        if (comeca_medida !== 1'b1 || canal !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: comeca=%b canal=%0d want 1/0",
                     comeca_medida, canal);
        end
        wait_idle(400, ok);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sweep_done: no return to INICIAL in 400 cycles");
        end
        n_assert++;
        if (n_partida != 8 || part_ch[0] != 4 || part_ch[1] != 4) begin
            n_fail++;
            $display("FAIL partida_count: got %0d (%0d/%0d) want 8 (4/4)",
                     n_partida, part_ch[0], part_ch[1]);
        end
        n_assert++;
        if (n_comeca != 2 || log_canal[0] != 0 || log_canal[1] != 1) begin
            n_fail++;
            $display("FAIL canal_seq: n=%0d seq=%0d,%0d want 2 0,1",
                     n_comeca, log_canal[0], log_canal[1]);
        end
        n_assert++;
        if (n_fv != 1 || n_pronto != 1) begin
            n_fail++;
            $display("FAIL sweep_pulses: fv=%0d pronto=%0d want 1/1", n_fv, n_pronto);
        end
        n_assert++;
        if (fast_gap != 6) begin
            n_fail++;
            $display("FAIL digito_latency: 2-cycle gaps=%0d want 6", fast_gap);
        end
        n_assert++;
        if (erro_canal !== 2'b00 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_end: erro=%b ocupado=%b want 00/0", erro_canal, ocupado);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit found;
        int k;
        int want;
        clear_stats();
        dead = 2'b10;
        start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (comeca_medida && canal == 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL ch1_trigger: no DISPARA on channel 1 in 200 cycles");
        end
        // DISPARA cycle, then TIMEOUT AGUARDA cycles, then the bit is visible.
        want = RETRY ? (2 * TMO + 3) : (TMO + 1);
        k = 0;
        while (erro_canal[1] !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        n_assert++;
        if (k != want || erro_canal !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_time: cycles=%0d erro=%b want %0d/10",
                     k, erro_canal, want);
        end
        wait_idle(200, ok);
        n_assert++;
        if (!ok || part_ch[1] != 0 || part_ch[0] != 4) begin
            n_fail++;
            $display("FAIL timeout_tx: ok=%b ch0=%0d ch1=%0d want 1/4/0",
                     ok, part_ch[0], part_ch[1]);
        end
        n_assert++;
        if (erro_canal !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_hold: erro=%b want 10", erro_canal);
        end
        dead = 2'b00;
    endtask

    task automatic test_continuous();
        bit found;
        int k;
        int n_int;
        clear_stats();
        continuo = 1'b1;
        dead = 2'b10;
        start();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (fim_varredura) begin
                found = 1'b1;
                break;
            end
            step();
        end
        n_assert++;
        if (!found || erro_canal !== 2'b10) begin
            n_fail++;
            $display("FAIL first_sweep: seen=%b erro=%b want 1/10", found, erro_canal);
        end
        dead = 2'b00;
        k = 0;
        n_int = 0;
        while (k < 100) begin
            step();
            k++;
            if (db_estado == 4'd8) n_int++;
            if (comeca_medida) break;
        end
        n_assert++;
        if (k != INTV + 2 || n_int != INTV) begin
            n_fail++;
            $display("FAIL interval: redisparo=%0d intervalo=%0d want %0d/%0d",
                     k, n_int, INTV + 2, INTV);
        end
        n_assert++;
        if (canal !== 1'b0 || erro_canal !== 2'b00) begin
            n_fail++;
            $display("FAIL second_sweep: canal=%0d erro=%b want 0/00", canal, erro_canal);
        end
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (fim_varredura) begin
                found = 1'b1;
                break;
            end
        end
        repeat (3) step();
        n_assert++;
        if (!found || db_estado !== 4'd8) begin
            n_fail++;
            $display("FAIL reach_interval: seen=%b estado=%0d want 1/8", found, db_estado);
        end
        parar = 1'b1;
        step();
        parar = 1'b0;
        n_assert++;
        if (pronto !== 1'b1 || db_estado !== 4'd9) begin
            n_fail++;
            $display("FAIL stop_interval: pronto=%b estado=%0d want 1/9", pronto, db_estado);
        end
        step();
        n_assert++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: estado=%0d ocupado=%b want 0/0", db_estado, ocupado);
        end
        continuo = 1'b0;
    endtask

    task automatic test_stop_in_flight();
        bit ok;
        bit found;
        clear_stats();
        start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (partida && canal == 1'b0 && indice_char == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        step();
        n_assert++;
        if (!found || db_estado !== 4'd5) begin
            n_fail++;
            $display("FAIL reach_espera: seen=%b estado=%0d want 1/5", found, db_estado);
        end
        parar = 1'b1;
        step();
        parar = 1'b0;
        wait_idle(300, ok);
        n_assert++;
        if (!ok || part_ch[0] != 4 || part_ch[1] != 0) begin
            n_fail++;
            $display("FAIL stop_chars: ok=%b ch0=%0d ch1=%0d want 1/4/0",
                     ok, part_ch[0], part_ch[1]);
        end
        n_assert++;
        if (n_comeca != 1 || n_pronto != 1 || n_fv != 0) begin
            n_fail++;
            $display("FAIL stop_pulses: comeca=%0d pronto=%0d fv=%0d want 1/1/0",
                     n_comeca, n_pronto, n_fv);
        end
    endtask

    task automatic test_timeout_tie();
        bit ok;
        int want_n;
        int want_c1;
        clear_stats();
        meas_delay = TMO;
        start();
        wait_idle(400, ok);
        n_assert++;
        if (!ok || erro_canal !== 2'b00 || n_partida != 8) begin
            n_fail++;
            $display("FAIL tie_wins: ok=%b erro=%b partida=%0d want 1/00/8",
                     ok, erro_canal, n_partida);
        end
        clear_stats();
        meas_delay = TMO + 1;
        start();
        wait_idle(600, ok);
        n_assert++;
        if (!ok || erro_canal !== 2'b11 || n_partida != 0) begin
            n_fail++;
            $display("FAIL late_echo: ok=%b erro=%b partida=%0d want 1/11/0",
                     ok, erro_canal, n_partida);
        end
        want_n  = RETRY ? 4 : 2;
        want_c1 = RETRY ? 0 : 1;
        n_assert++;
        if (n_comeca != want_n || log_canal[1] != want_c1) begin
            n_fail++;
            $display("FAIL retry_seq: disparos=%0d second_canal=%0d want %0d/%0d",
                     n_comeca, log_canal[1], want_n, want_c1);
        end
        meas_delay = 10;
    endtask

    task automatic test_reset_async();
        bit found;
        clear_stats();
        start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (partida && canal == 1'b1 && indice_char == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_assert++;
        if (!found || db_estado !== 4'd4) begin
            n_fail++;
            $display("FAIL reach_tx: seen=%b estado=%0d want 1/4", found, db_estado);
        end
        #1 reset = 1'b1;
        #1;
        n_assert++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0 || partida !== 1'b0) begin
            n_fail++;
            $display("FAIL async_state: estado=%0d ocupado=%b partida=%b want 0/0/0",
                     db_estado, ocupado, partida);
        end
        n_assert++;
        if (canal !== 1'b0 || indice_char !== 2'd0) begin
            n_fail++;
            $display("FAIL async_idx: canal=%0d idx=%0d want 0/0", canal, indice_char);
        end
        step();
        reset = 1'b0;
        step();
        n_assert++;
        if (db_estado !== 4'd0 || comeca_medida !== 1'b0 || zera !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: estado=%0d comeca=%b zera=%b want 0/0/1",
                     db_estado, comeca_medida, zera);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_sweep();
        test_timeout();
        test_continuous();
        test_stop_in_flight();
        test_timeout_tie();
        test_reset_async();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
